tone_player: RTL and testbench
==============================

# tone_player

Plays a short multi-note jingle as a square wave when it receives a tone code. It sits downstream of the sound event controller and consumes that block's `tone[3:0]` / `enable_out` pair. Its `audio_out` feeds the board audio/buzzer pin. Codes 1–6 each select a fixed note sequence held in a ROM in the shared package; code 0 and codes 7–15 mean silence.

## Interface
Parameters:
- `HP_W`, 17: width of the note half-period field, in clocks.
- `GAP_MS`, 10: length of the silent gap between consecutive notes, in ms ticks.

Ports:
- `clk`  in  1: system clock (50 MHz).
- `resetN`  in  1: synchronous reset, active low.
- `enable`  in  1: sound enable, driven by the controller's `enable_out`.
- `tone`  in  4: jingle code, driven by the controller's `tone`.
- `oneMsPulse`  in  1: one-clock strobe, once per millisecond.
- `audio_out`  out  1: square-wave audio.
- `busy`  out  1: high while in PLAY or GAP.
- `note_idx`  out  2: index of the current note within the jingle.

## Operation
- States:
  - IDLE: silent.
  - PLAY: tone generator running.
  - GAP: silent pause between notes.
- Registered internally: `enable_d` (previous `enable`) and `cur_tone` (latched code).
- Trigger: `trig = enable && tone inside 1..6 && (!enable_d || tone != cur_tone)`.
  - Active in any state.
  - A new code pre-empts a running jingle and restarts it at note 0.
- On `trig`:
  - `cur_tone <= tone`, `note_idx <= 0`, ms counter cleared, wave counter cleared.
  - `audio_out <= 0`, state goes to PLAY.
- In PLAY:
  - The ms counter increments on `oneMsPulse`.
  - When the pulse arrives with `ms_cnt == dur-1`:
    - If the current note is the last one, go to IDLE.
    - Otherwise go to GAP with `ms_cnt` cleared.
- In GAP:
  - After `GAP_MS` pulses, `note_idx++`, go to PLAY.
- `enable == 0` in any state: next cycle IDLE, `audio_out = 0`, `cur_tone <= 0`.
- A jingle plays exactly once per trigger. A steady `enable` and steady `tone` do not replay it.
- Wave generator, active only in PLAY:
  - Counter runs 0..half-1. `audio_out` toggles when the count reaches half-1, then the counter returns to 0.
  - `half == 0` means a rest: `audio_out` is held at 0.
- Jingle ROM, as note(half-period, ms):
  - 1 hit: A4(56818, 100), A3(113636, 150).
  - 2 levelUp: C5(47778, 80), E5(37922, 80), G5(31888, 80), C6(23889, 80).
  - 3 gameOver: G5(31888, 250), E5(37922, 250), C5(47778, 250).
  - 4 heart: E5(37922, 60), G5(31888, 60).
  - 5 diamond: C6(23889, 50), G5(31888, 50), C6(23889, 50).
  - 6 shoot: C6(23889, 30).
- Widths:
  - Duration field: 8 bits, values 1..255.
  - Length field: 3 bits, values 1..4.
  - Half-period field: `HP_W` bits.
  - All counters are sized to their fields and never wrap in normal use.

## Timing
- Reset (synchronous, `resetN = 0` at a clock edge): state IDLE, `audio_out = 0`, `busy = 0`, `note_idx = 0`, `cur_tone = 0`, `enable_d = 0`, all counters 0.
- Reset mid-jingle aborts it on that edge. No replay after release unless `trig` asserts again.
- Trigger latency: `trig` sampled at edge N gives `busy = 1` after edge N.
  - First `audio_out` rise comes `half` cycles after the first PLAY cycle.
- Note length: exactly `dur` `oneMsPulse` strobes counted in PLAY, measured from PLAY entry.
  - A pulse coincident with PLAY entry is not counted.
- Simultaneous events, in priority order:
  1. `!enable`
  2. `trig`
  3. duration or gap expiry
- A `tone` change to 0 or 7..15 while playing does not stop the current jingle.

## Structure
- `sound_pkg` contains:
  - The state enum.
  - Note half-period constants: A3, A4, C5, E5, G5, C6.
  - Typedef `note_t {half, dur}` and the jingle ROM function `jingle_note(code, idx)`.
  - `jingle_len(code)`.
  - `TONE_HIT` .. `TONE_SHOOT` codes, shared with the controller.
- Sub-module `square_wave_gen(clk, resetN, run, half, wave)` holds the wave counter and the toggle flop.
  - `run = 0` clears it synchronously.

## Test plan
- Reset, then `enable = 1`, `tone = 6` → `busy` rises 1 cycle later.
  - `audio_out` toggles every 23889 clocks.
  - After 30 ms pulses: `busy = 0`, `audio_out = 0`.
  - No replay while the inputs are held.
- `tone = 2` → `note_idx` steps 0, 1, 2, 3 with 10-pulse gaps and 80-pulse notes.
  - Half-periods are 47778, 37922, 31888, 23889.
  - Total 350 pulses until `busy = 0`.
- Play `tone = 3`; at pulse 100 switch to `tone = 1` → restart at `note_idx = 0` with half-period 56818 on the next cycle.
- `enable` drops mid-note of `tone = 5` → next cycle IDLE, `audio_out = 0`.
  - `enable` high again with the same code → the jingle restarts.
- `tone = 9` or `tone = 0` with `enable = 1` → stays IDLE, `busy = 0`.
- `resetN = 0` for one cycle during GAP of `tone = 4` → all outputs 0 on the following cycle; no playback after release.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared sound definitions: tone codes, note half-periods and the jingle ROM
// used by the event controller and the tone player.
package sound_pkg;

    localparam int HALF_W = 17;
    localparam int DUR_W  = 8;
    localparam int LEN_W  = 3;
    localparam int IDX_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Half-periods in 50 MHz clocks
    localparam logic [HALF_W-1:0] HP_A3 = 17'd113636;
    localparam logic [HALF_W-1:0] HP_A4 = 17'd56818;
    localparam logic [HALF_W-1:0] HP_C5 = 17'd47778;
    localparam logic [HALF_W-1:0] HP_E5 = 17'd37922;
    localparam logic [HALF_W-1:0] HP_G5 = 17'd31888;
    localparam logic [HALF_W-1:0] HP_C6 = 17'd23889;

    localparam logic [3:0] TONE_HIT       = 4'd1;
    localparam logic [3:0] TONE_LEVEL_UP  = 4'd2;
    localparam logic [3:0] TONE_GAME_OVER = 4'd3;
    localparam logic [3:0] TONE_HEART     = 4'd4;
    localparam logic [3:0] TONE_DIAMOND   = 4'd5;
    localparam logic [3:0] TONE_SHOOT     = 4'd6;

    typedef struct packed {
        logic [HALF_W-1:0] half;
        logic [DUR_W-1:0]  dur;
    } note_t;

    function automatic note_t mk_note(input logic [HALF_W-1:0] half,
                                      input logic [DUR_W-1:0]  dur);
        note_t n;
        n.half = half;
        n.dur  = dur;
        return n;
    endfunction

    function automatic logic is_jingle(input logic [3:0] code);
        return (code >= TONE_HIT) && (code <= TONE_SHOOT);
    endfunction

    function automatic logic [LEN_W-1:0] jingle_len(input logic [3:0] code);
        case (code)
            TONE_HIT:       return 3'd2;
            TONE_LEVEL_UP:  return 3'd4;
            TONE_GAME_OVER: return 3'd3;
            TONE_HEART:     return 3'd2;
            TONE_DIAMOND:   return 3'd3;
            default:        return 3'd1;
        endcase
    endfunction

    function automatic note_t jingle_note(input logic [3:0]       code,
                                          input logic [IDX_W-1:0] idx);
        note_t n;
        n = mk_note('0, 8'd1);
        case (code)
            TONE_HIT:
                n = (idx == 2'd0) ? mk_note(HP_A4, 8'd100) : mk_note(HP_A3, 8'd150);
            TONE_LEVEL_UP:
                case (idx)
                    2'd0:    n = mk_note(HP_C5, 8'd80);
                    2'd1:    n = mk_note(HP_E5, 8'd80);
                    2'd2:    n = mk_note(HP_G5, 8'd80);
                    default: n = mk_note(HP_C6, 8'd80);
                endcase
            TONE_GAME_OVER:
                case (idx)
                    2'd0:    n = mk_note(HP_G5, 8'd250);
                    2'd1:    n = mk_note(HP_E5, 8'd250);
                    default: n = mk_note(HP_C5, 8'd250);
                endcase
            TONE_HEART:
                n = (idx == 2'd0) ? mk_note(HP_E5, 8'd60) : mk_note(HP_G5, 8'd60);
            TONE_DIAMOND:
                n = (idx == 2'd1) ? mk_note(HP_G5, 8'd50) : mk_note(HP_C6, 8'd50);
            TONE_SHOOT:
                n = mk_note(HP_C6, 8'd30);
            default: ;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tone_player_square_wave_gen.sv
// Square-wave generator: toggles its output every `half` clocks while run is
// high; a zero half-period is a rest and holds the output low.
module square_wave_gen #(
    parameter int HP_W = 17
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            run,
    input  logic [HP_W-1:0] half,
    output logic            wave
);

    logic [HP_W-1:0] cnt_q, cnt_d;
    logic            wave_q, wave_d;

    always_comb begin
        // NOTE: defaults first so every path assigns cnt_d/wave_d; a missing branch would infer a latch.
        cnt_d  = cnt_q;
        wave_d = wave_q;
        if (!run || half == '0) begin
            cnt_d  = '0;
            wave_d = 1'b0;
        end else if (cnt_q >= half - 1'b1) begin
            cnt_d  = '0;
            wave_d = ~wave_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state updates use <= so all flops sample pre-edge values; reset is synchronous to clk.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/tone_player.sv
// Plays the jingle selected by a tone code once per trigger, as a square wave
// with silent gaps between notes.
module tone_player
    import sound_pkg::*;
#(
    parameter int HP_W   = 17,
    parameter int GAP_MS = 10
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       enable,
    input  logic [3:0] tone,
    input  logic       oneMsPulse,
    output logic       audio_out,
    output logic       busy,
    output logic [1:0] note_idx
);

    localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_MS - 1);

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             prev_enable_q, prev_enable_d;
    logic [3:0]       cur_tone_q, cur_tone_d;
    logic [IDX_W-1:0] note_idx_q, note_idx_d;
    logic [DUR_W-1:0] ms_cnt_q, ms_cnt_d;

    note_t            cur_note;
    logic             last_note;
    logic             trig;
    logic             wave_run;

    assign cur_note  = jingle_note(cur_tone_q, note_idx_q);
    assign last_note = (LEN_W'(note_idx_q) == jingle_len(cur_tone_q) - 3'd1);

    // A held code never retriggers; only a fresh enable or a different code does
    assign trig = enable && is_jingle(tone) && (!prev_enable_q || tone != cur_tone_q);

    always_comb begin
        state_d       = state_q;
        cur_tone_d    = cur_tone_q;
        note_idx_d    = note_idx_q;
        ms_cnt_d      = ms_cnt_q;
        prev_enable_d = enable;

        if (!enable) begin
            state_d    = ST_IDLE;
            cur_tone_d = 4'd0;
        end else if (trig) begin
            state_d    = ST_PLAY;
            cur_tone_d = tone;
            note_idx_d = '0;
            ms_cnt_d   = '0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (oneMsPulse) begin
                        if (ms_cnt_q == cur_note.dur - DUR_W'(1)) begin
                            state_d  = last_note ? ST_IDLE : ST_GAP;
                            ms_cnt_d = '0;
                        end else begin
                            ms_cnt_d = ms_cnt_q + DUR_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (oneMsPulse) begin
                        if (ms_cnt_q == GAP_LAST) begin
                            state_d    = ST_PLAY;
                            ms_cnt_d   = '0;
                            note_idx_d = note_idx_q + IDX_W'(1);
                        end else begin
                            ms_cnt_d = ms_cnt_q + DUR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Clearing the generator on the edge that leaves PLAY or restarts keeps audio low outside notes
    assign wave_run = (state_q == ST_PLAY) && (state_d == ST_PLAY) && !trig;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            prev_enable_q <= 1'b0;
            cur_tone_q    <= 4'd0;
            note_idx_q    <= '0;
            ms_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            prev_enable_q <= prev_enable_d;
            cur_tone_q    <= cur_tone_d;
            note_idx_q    <= note_idx_d;
            ms_cnt_q      <= ms_cnt_d;
        end
    end

    square_wave_gen #(
        .HP_W (HP_W)
    ) u_wave (
        .clk    (clk),
        .resetN (resetN),
        .run    (wave_run),
        .half   (HP_W'(cur_note.half)),
        .wave   (audio_out)
    );

    assign busy     = busy_q;
    assign note_idx = note_idx_q;

endmodule

// File: tb/tb_tone_player.sv
// Self-checking bench for tone_player: a cycle-level behavioural model of the
// jingle rules is compared against the DUT every cycle, plus literal checks.
module tb_tone_player;

    localparam int GAP = 10;

    localparam int HALF_TAB [0:6][0:3] = '{
        '{0, 0, 0, 0},
        '{56818, 113636, 0, 0},
        '{47778, 37922, 31888, 23889},
        '{31888, 37922, 47778, 0},
        '{37922, 31888, 0, 0},
        '{23889, 31888, 23889, 0},
        '{23889, 0, 0, 0}
    };
    localparam int DUR_TAB [0:6][0:3] = '{
        '{0, 0, 0, 0},
        '{100, 150, 0, 0},
        '{80, 80, 80, 80},
        '{250, 250, 250, 0},
        '{60, 60, 0, 0},
        '{50, 50, 50, 0},
        '{30, 0, 0, 0}
    };
    localparam int LEN_TAB [0:6] = '{0, 2, 4, 3, 2, 3, 1};

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] tone = 4'd0;
    logic       oneMsPulse = 1'b0;
    logic       audio_out;
    logic       busy;
    logic [1:0] note_idx;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: whether a jingle is sounding, which note, pulses counted in
    // the current note or gap, and clocks elapsed since the note started.
    bit m_busy = 0;
    bit m_gap  = 0;
    int m_idx  = 0;
    int m_tone = 0;
    int m_pulses = 0;
    int m_t = 0;
    bit m_en_d = 0;

    tone_player #(
        .HP_W   (17),
        .GAP_MS (GAP)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .enable     (enable),
        .tone       (tone),
        .oneMsPulse (oneMsPulse),
        .audio_out  (audio_out),
        .busy       (busy),
        .note_idx   (note_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_step();
        bit trig;
        trig = 0;
        if (!resetN) begin
            m_busy = 0; m_gap = 0; m_idx = 0; m_tone = 0;
            m_pulses = 0; m_t = 0; m_en_d = 0;
        end else begin
            trig = enable && (tone >= 4'd1) && (tone <= 4'd6) &&
                   (!m_en_d || int'(tone) != m_tone);
            if (!enable) begin
                m_busy = 0;
                m_tone = 0;
            end else if (trig) begin
                m_tone = int'(tone); m_busy = 1; m_gap = 0;
                m_idx = 0; m_pulses = 0; m_t = 0;
            end else if (m_busy) begin
                if (!m_gap) begin
                    m_t++;
                    if (oneMsPulse) begin
                        m_pulses++;
                        if (m_pulses == DUR_TAB[m_tone][m_idx]) begin
                            m_pulses = 0;
                            if (m_idx == LEN_TAB[m_tone] - 1) m_busy = 0;
                            else m_gap = 1;
                        end
                    end
                end else if (oneMsPulse) begin
                    m_pulses++;
                    if (m_pulses == GAP) begin
                        m_pulses = 0; m_gap = 0; m_idx++; m_t = 0;
                    end
                end
            end
            m_en_d = enable;
        end
    endtask

    function automatic int exp_audio();
        int h;
        if (!m_busy || m_gap) return 0;
        h = HALF_TAB[m_tone][m_idx];
        if (h == 0) return 0;
        return (m_t / h) % 2;
    endfunction

    // Compare process: advance the model on each edge, check 1 time unit later
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("busy", int'(busy), int'(m_busy));
            check("audio_out", int'(audio_out), exp_audio());
            check("note_idx", int'(note_idx), m_idx);
        end
    end

    initial begin
        #990000;
        $display("FAIL watchdog: simulation time limit reached, busy=%0b", busy);
        $fatal(1, "watchdog");
    end

    // Runs until busy drops or max_pulses were issued; reports pulses issued,
    // the first cycle with audio high and the sequence of note indices seen.
    task automatic drive(input int period, input int max_pulses, input int max_cycles,
                         output int pulses, output int rise_k, output int trace);
        int k;
        int last_idx;
        bit pick;
        pulses = 0; rise_k = -1; k = 0;
        last_idx = int'(note_idx);
        trace = last_idx;
        forever begin
            @(negedge clk);
            k++;
            oneMsPulse = 1'b0;
            if (busy !== 1'b1) break;
            if (audio_out === 1'b1 && rise_k < 0) rise_k = k;
            if (int'(note_idx) != last_idx) begin
                last_idx = int'(note_idx);
                trace = trace * 10 + last_idx;
            end
            if (pulses >= max_pulses) break;
            if (k >= max_cycles) begin
                n_tests++;
                n_fail++;
                $display("FAIL drive_timeout: %0d cycles, busy=%0b, expected completion", k, busy);
                break;
            end
            pick = (period == 0) ? ($urandom_range(0, 2) == 0) : ((k % period) == 0);
            if (pick) begin
                oneMsPulse = 1'b1;
                pulses++;
            end
        end
    endtask

    task automatic start_jingle(input logic [3:0] code);
        @(negedge clk);
        enable = 1'b1;
        tone = code;
        oneMsPulse = 1'b0;
        @(negedge clk);
        check($sformatf("busy_after_trig_%0d", code), int'(busy), 1);
    endtask

    initial begin
        int p, r, tr;

        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_audio", int'(audio_out), 0);
        check("reset_note_idx", int'(note_idx), 0);
        resetN = 1'b1;
        @(negedge clk);

        // shoot: one C6 note of 30 pulses, first rise after 23889 clocks
        start_jingle(4'd6);
        drive(800, 1000, 30000, p, r, tr);
        check("shoot_pulses", p, 30);
        check("shoot_first_rise", r, 23889);
        check("shoot_audio_idle", int'(audio_out), 0);
        repeat (100) begin
            @(negedge clk);
            oneMsPulse = ($urandom_range(0, 1) == 0);
        end
        @(negedge clk);
        oneMsPulse = 1'b0;
        check("shoot_no_replay", int'(busy), 0);

        // levelUp: 4 notes of 80 with 10-pulse gaps
        start_jingle(4'd2);
        drive(0, 1000, 5000, p, r, tr);
        check("levelup_pulses", p, 350);
        check("levelup_idx_trace", tr, 123);

        // gameOver pre-empted by hit after 100 pulses
        start_jingle(4'd3);
        drive(0, 100, 2000, p, r, tr);
        tone = 4'd1;
        @(negedge clk);
        check("restart_busy", int'(busy), 1);
        check("restart_note_idx", int'(note_idx), 0);
        drive(0, 1000, 5000, p, r, tr);
        check("hit_pulses", p, 260);
        check("hit_idx_trace", tr, 1);

        // diamond interrupted by enable, then replayed with the same code
        start_jingle(4'd5);
        drive(0, 20, 1000, p, r, tr);
        enable = 1'b0;
        @(negedge clk);
        check("disable_busy", int'(busy), 0);
        check("disable_audio", int'(audio_out), 0);
        enable = 1'b1;
        @(negedge clk);
        check("reenable_busy", int'(busy), 1);
        check("reenable_note_idx", int'(note_idx), 0);
        drive(0, 1000, 5000, p, r, tr);
        check("diamond_pulses", p, 170);

        // silence codes never start anything
        tone = 4'd9;
        repeat (20) @(negedge clk);
        check("tone9_busy", int'(busy), 0);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        tone = 4'd0;
        repeat (20) @(negedge clk);
        check("tone0_busy", int'(busy), 0);

        // heart: first note with sparse pulses, then reset during the gap
        start_jingle(4'd4);
        drive(640, 60, 40000, p, r, tr);
        check("heart_pulses", p, 60);
        check("heart_first_rise", r, 37922);
        check("heart_gap_busy", int'(busy), 1);
        check("heart_gap_idx", int'(note_idx), 0);
        check("heart_gap_audio", int'(audio_out), 0);
        drive(2, 3, 100, p, r, tr);
        resetN = 1'b0;
        tone = 4'd0;
        @(negedge clk);
        check("midreset_busy", int'(busy), 0);
        check("midreset_audio", int'(audio_out), 0);
        check("midreset_note_idx", int'(note_idx), 0);
        resetN = 1'b1;
        repeat (30) @(negedge clk);
        check("postreset_no_play", int'(busy), 0);

        // random soak against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            resetN = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            if ($urandom_range(0, 24) == 0)
                tone = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                   : 4'($urandom_range(1, 6));
            oneMsPulse = ($urandom_range(0, 1) == 0);
        end
        @(negedge clk);
        resetN = 1'b1;
        oneMsPulse = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
